serializer_10b: RTL and testbench
=================================

# serializer_10b

Parallel-to-serial stage directly downstream of the 8b/10b encoder. Accepts one 10-bit encoded symbol per valid/ready handshake into a one-entry holding buffer and shifts it out one bit per clock, MSB (bit 9, code bit `a`) first. It marks symbol boundaries for the line interface and flags underruns; optionally it fills gaps with K28.5 commas.

## Interface
- `FILL_NEG`, 10'b0011111010, K28.5 pattern for RD−, as bits [9:0] in the encoder's bit order.
- `FILL_POS`, 10'b1100000101, K28.5 pattern for RD+.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  **synchronous, active-low reset**, sampled on the rising edge of `clk`.
- `sym_in`  in  10  encoded symbol; bit 9 is transmitted first.
- `sym_valid`  in  1  `sym_in` is valid.
- `sym_ready`  out  1  holding buffer empty; `sym_ready = !hold_full` (combinational from a register).
- `ser_out`  out  1  registered serial bit.
- `ser_sync`  out  1  registered; high during the first bit (bit 9) of every transmitted symbol, whether data or fill.
- `underrun`  out  1  registered one-cycle pulse, asserted when a symbol boundary finds no data after the first data symbol.
- `active`  out  1  registered; high while in SHIFT.

## Operation
- **Transfer**: a transfer occurs on a rising edge where `sym_valid && sym_ready` and `rst` = 1. Inputs are ignored while `rst` = 0.
- **State**: `shreg[9:0]`, `bit_cnt` (4 bits, 0..9), `hold[9:0]`, `hold_full`, `fill_rd`, `seen_data`, and FSM `{IDLE, SHIFT}`.
- **Reset** (`rst` = 0 at an edge):
  - `ser_out`, `ser_sync`, `underrun`, `active`, `hold_full`, `fill_rd`, `seen_data`, `bit_cnt` all become 0.
  - FSM goes to IDLE.
  - `sym_ready` is therefore 1 in the first cycle after reset.
  - Reset mid-symbol discards the partial symbol and any held symbol.
- **IDLE**:
  - `ser_out` = 0, `ser_sync` = 0.
  - On a transfer, `sym_in` loads directly into `shreg` (bypassing `hold`). At the same edge: `ser_out <= sym_in[9]`, `ser_sync <= 1`, `bit_cnt <= 0`, FSM → SHIFT, `seen_data <= 1`.
- **SHIFT, mid-symbol** (`bit_cnt` < 9):
  - `ser_out <= shreg[8 - bit_cnt]` (equivalently, shift left and output the MSB).
  - `bit_cnt` increments; `ser_sync <= 0`.
  - A transfer in this phase loads `hold` and sets `hold_full`.
- **SHIFT, symbol boundary** (`bit_cnt` = 9). The next symbol is selected in priority order:
  1. If `hold_full`: load `hold`, clear `hold_full`.
  2. Else, if a transfer occurs this edge: load `sym_in` (bypass).
  3. Else, no data:
     - `underrun <= seen_data`.
     - With fill enabled: load `fill_rd ? FILL_POS : FILL_NEG` and toggle `fill_rd`.
     - Without fill: FSM → IDLE and `ser_out <= 0`.
  - On any load at the boundary: `bit_cnt <= 0`, `ser_sync <= 1`, and `ser_out` becomes bit 9 of the loaded symbol.
- **Simultaneous events**: a boundary drain of `hold` and a new transfer cannot coincide, because `sym_ready` is 0 whenever `hold_full` is 1. A new transfer is accepted in the cycle after the drain.
- **Throughput**: one symbol per 10 clocks, continuous and with no gaps, provided the source re-asserts valid within the symbol period.

## Timing
- **Latency**: a transfer at edge N from IDLE puts bit 9 on `ser_out` in the cycle after edge N; bit 0 appears after edge N+9.
- **Back-to-back**: the next symbol's bit 9 appears after edge N+10.
- **Backpressure**: `sym_ready` falls the cycle after a mid-symbol transfer and rises the cycle after the boundary that drains `hold`.
- **`underrun`**: asserts for exactly one cycle, aligned with the first bit of the fill symbol (or with the return to IDLE).

## Configuration
- Macro `SERIALIZER_10B_IDLE_COMMA_EN`.
- **Defined**:
  - The FSM leaves IDLE on the first edge after reset with `rst` = 1 and starts transmitting `FILL_NEG`.
  - Underrun boundaries send alternating K28.5 patterns, starting RD−.
  - The line never goes to IDLE except through reset.
- **Undefined**:
  - There are no fill symbols and `fill_rd` is not used.
  - An underrun returns the FSM to IDLE, with `ser_out` held at 0 until the next transfer.

## Test plan
- **Single symbol, fill undefined**: reset, then a transfer of 10'b1001110100 → `ser_out` sequence 1,0,0,1,1,1,0,1,0,0 starting one cycle after the transfer; `ser_sync` high on the first bit only; then IDLE, `ser_out` = 0, `underrun` pulses once.
- **Back-to-back streaming**: 4 symbols with valid held high → 40 contiguous bits, `ser_sync` every 10 cycles, `underrun` = 0 throughout, `sym_ready` low between each buffer fill and its drain.
- **Backpressure**: valid held continuously with changing data → no symbol is lost or duplicated; each symbol is accepted exactly once per 10 cycles.
- **Comma fill, macro defined**: reset with no input → `ser_out` shows 0011111010, then 1100000101, then 0011111010; `underrun` = 0 before the first data. Then one data symbol followed by starvation → `underrun` pulses once, and fill resumes with the current `fill_rd`.
- **Reset mid-symbol**: `rst` = 0 at bit 4 with `hold_full` = 1 → the next cycle shows all outputs 0 and `sym_ready` = 1; the held symbol is never transmitted.
- **Boundary bypass**: `hold` empty and a transfer on exactly the `bit_cnt` = 9 edge → the new symbol's bit 9 appears in the next cycle with no gap and no `underrun`.

Source files
------------

// File: rtl/serializer_10b.sv
// 10-bit parallel-to-serial stage: one-entry holding buffer, MSB-first shift-out,
// symbol sync and underrun flags. Define SERIALIZER_10B_IDLE_COMMA_EN to fill gaps with K28.5.
module serializer_10b (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sym_in,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic       ser_out,
    output logic       ser_sync,
    output logic       underrun,
    output logic       active
);
`ifdef SERIALIZER_10B_IDLE_COMMA_EN
    localparam logic [9:0] FILL_NEG = 10'b0011111010;
    localparam logic [9:0] FILL_POS = 10'b1100000101;
    logic       fill_rd;
    logic       fill_rd_nxt;
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [9:0] shreg;
    logic [9:0] shreg_nxt;
    logic [9:0] hold;
    logic [9:0] hold_nxt;
    logic [3:0] bit_cnt;
    logic [3:0] bit_cnt_nxt;
    logic       hold_full;
    logic       hold_full_nxt;
    logic       seen_data;
    logic       seen_data_nxt;
    logic       ser_out_nxt;
    logic       ser_sync_nxt;
    logic       underrun_nxt;
    logic       xfer;
    logic       load;
    logic       load_data;
    logic [9:0] load_sym;

    assign sym_ready = !hold_full;
    assign xfer      = sym_valid && sym_ready;

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        hold_nxt      = hold;
        bit_cnt_nxt   = bit_cnt;
        hold_full_nxt = hold_full;
        seen_data_nxt = seen_data;
        ser_out_nxt   = 1'b0;
        ser_sync_nxt  = 1'b0;
        underrun_nxt  = 1'b0;
        load          = 1'b0;
        load_data     = 1'b0;
        load_sym      = sym_in;
`ifdef SERIALIZER_10B_IDLE_COMMA_EN
        fill_rd_nxt   = fill_rd;
`endif
        case (state)
            IDLE: begin
                if (xfer) begin
                    load      = 1'b1;
                    load_data = 1'b1;
`ifdef SERIALIZER_10B_IDLE_COMMA_EN
                end else begin
                    load        = 1'b1;
                    load_sym    = fill_rd ? FILL_POS : FILL_NEG;
                    fill_rd_nxt = !fill_rd;
`endif
                end
            end
            SHIFT: begin
                if (bit_cnt != 4'd9) begin
                    ser_out_nxt = shreg[4'd8 - bit_cnt];
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (xfer) begin
                        hold_nxt      = sym_in;
                        hold_full_nxt = 1'b1;
                    end
                end else if (hold_full) begin
                    // sym_ready is low here, so no transfer can collide with the drain
                    load          = 1'b1;
                    load_data     = 1'b1;
                    load_sym      = hold;
                    hold_full_nxt = 1'b0;
                end else if (xfer) begin
                    load      = 1'b1;
                    load_data = 1'b1;
                end else begin
                    underrun_nxt = seen_data;
`ifdef SERIALIZER_10B_IDLE_COMMA_EN
                    load         = 1'b1;
                    load_sym     = fill_rd ? FILL_POS : FILL_NEG;
                    fill_rd_nxt  = !fill_rd;
`else
                    state_nxt    = IDLE;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (load) begin
            shreg_nxt    = load_sym;
            ser_out_nxt  = load_sym[9];
            ser_sync_nxt = 1'b1;
            bit_cnt_nxt  = 4'd0;
            state_nxt    = SHIFT;
            if (load_data) seen_data_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            hold_full <= 1'b0;
            seen_data <= 1'b0;
            ser_out   <= 1'b0;
            ser_sync  <= 1'b0;
            underrun  <= 1'b0;
            active    <= 1'b0;
`ifdef SERIALIZER_10B_IDLE_COMMA_EN
            fill_rd   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            hold_full <= hold_full_nxt;
            seen_data <= seen_data_nxt;
            ser_out   <= ser_out_nxt;
            ser_sync  <= ser_sync_nxt;
            underrun  <= underrun_nxt;
            active    <= (state_nxt == SHIFT);
`ifdef SERIALIZER_10B_IDLE_COMMA_EN
            fill_rd   <= fill_rd_nxt;
`endif
        end
    end

    // Data registers carry no reset; hold_full and the FSM gate their use.
    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
        hold  <= hold_nxt;
    end
endmodule

// File: tb/tb_serializer_10b.sv
// Bench for serializer_10b: a symbol-level line model (busy symbol, bit index,
// pending queue) checked every cycle, plus literal waveform expectations.
module tb_serializer_10b;
    logic       clk;
    logic       rst;
    logic [9:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic       ser_out;
    logic       ser_sync;
    logic       underrun;
    logic       active;

    int checks = 0;
    int errors = 0;

    serializer_10b dut (
        .clk      (clk),
        .rst      (rst),
        .sym_in   (sym_in),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .ser_out  (ser_out),
        .ser_sync (ser_sync),
        .underrun (underrun),
        .active   (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SERIALIZER_10B_IDLE_COMMA_EN
    localparam logic [9:0] FILL_NEG = 10'b0011111010;
    localparam logic [9:0] FILL_POS = 10'b1100000101;
`endif

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Line model: the symbol on the wire, which of its bits is showing, and what waits.
    logic [9:0] m_sym;
    int         m_idx;
    bit         m_busy;
    bit         m_seen;
    bit         m_fill_rd;
    bit         m_under;
    bit         m_live = 0;
    bit         m_xfer;
    logic [9:0] m_pend[$];

    task automatic m_start(input logic [9:0] s, input bit data);
        m_sym  = s;
        m_idx  = 0;
        m_busy = 1;
        if (data) m_seen = 1;
    endtask

    task automatic m_gap();
`ifdef SERIALIZER_10B_IDLE_COMMA_EN
        m_start(m_fill_rd ? FILL_POS : FILL_NEG, 0);
        m_fill_rd = !m_fill_rd;
`else
        m_busy = 0;
`endif
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 0; m_seen = 0; m_fill_rd = 0; m_under = 0; m_idx = 0;
            m_pend.delete();
            m_live = 1;
        end else begin
            m_xfer  = sym_valid && (m_pend.size() == 0);
            m_under = 0;
            if (!m_busy) begin
                if (m_xfer) m_start(sym_in, 1);
`ifdef SERIALIZER_10B_IDLE_COMMA_EN
                else m_gap();
`endif
            end else if (m_idx < 9) begin
                m_idx++;
                if (m_xfer) m_pend.push_back(sym_in);
            end else if (m_pend.size() > 0) begin
                m_start(m_pend.pop_front(), 1);
            end else if (m_xfer) begin
                m_start(sym_in, 1);
            end else begin
                m_under = m_seen;
                m_gap();
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("ser_out",   {9'd0, ser_out},   {9'd0, m_busy ? m_sym[9 - m_idx] : 1'b0});
            check("ser_sync",  {9'd0, ser_sync},  {9'd0, m_busy && m_idx == 0});
            check("underrun",  {9'd0, underrun},  {9'd0, m_under});
            check("active",    {9'd0, active},    {9'd0, m_busy});
            check("sym_ready", {9'd0, sym_ready}, {9'd0, m_pend.size() == 0});
        end
    end

    task automatic send(input logic [9:0] s);
        int n = 0;
        sym_valid = 1'b1;
        sym_in    = s;
        while (!sym_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!sym_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: sym_ready stuck at %b, required 1", sym_ready);
        end
        @(negedge clk);
        sym_valid = 1'b0;
    endtask

    logic [9:0]  word;
    logic [9:0]  syncs;
    logic [29:0] stream;

    initial begin
        rst = 1'b0; sym_valid = 1'b0; sym_in = 10'd0;
        repeat (3) @(negedge clk);
        check("reset_ser_out", {9'd0, ser_out}, 10'd0);
        check("reset_ready",   {9'd0, sym_ready}, 10'd1);
        check("reset_active",  {9'd0, active}, 10'd0);
        rst = 1'b1;

`ifdef SERIALIZER_10B_IDLE_COMMA_EN
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            stream = {stream[28:0], ser_out};
        end
        word = stream[29:20]; check("fill_first",  word, 10'b0011111010);
        word = stream[19:10]; check("fill_second", word, 10'b1100000101);
        word = stream[9:0];   check("fill_third",  word, 10'b0011111010);
`else
        @(negedge clk);
        send(10'b1001110100);
        word = 10'd0; syncs = 10'd0;
        for (int i = 0; i < 10; i++) begin
            word = {word[8:0], ser_out};
            if (ser_sync) syncs = syncs + ((i == 0) ? 10'd1 : 10'd100);
            @(negedge clk);
        end
        check("single_bits",     word, 10'b1001110100);
        check("single_sync",     syncs, 10'd1);
        check("single_underrun", {9'd0, underrun}, 10'd1);
        check("single_idle_out", {9'd0, ser_out}, 10'd0);
        @(negedge clk);
        check("single_under_one", {9'd0, underrun}, 10'd0);
`endif

        // back-to-back streaming
        repeat (12) @(negedge clk);
        for (int i = 0; i < 4; i++) send(10'($urandom));
        repeat (40) @(negedge clk);

        // continuous valid with random gaps
        for (int i = 0; i < 30; i++) begin
            send(10'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 14)) @(negedge clk);
        end
        repeat (25) @(negedge clk);

        // transfer exactly on the boundary edge with hold empty
        send(10'b1010101010);
        repeat (9) @(negedge clk);
        send(10'b0110011001);
`ifndef SERIALIZER_10B_IDLE_COMMA_EN
        check("bypass_sync",  {9'd0, ser_sync}, 10'd1);
        check("bypass_under", {9'd0, underrun}, 10'd0);
        check("bypass_bit9",  {9'd0, ser_out},  10'd0);
`endif
        repeat (25) @(negedge clk);

        // reset mid-symbol with a held symbol
        send(10'b1111100000);
        send(10'b1000000001);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ser_out",  {9'd0, ser_out},   10'd0);
        check("rst_ser_sync", {9'd0, ser_sync},  10'd0);
        check("rst_underrun", {9'd0, underrun},  10'd0);
        check("rst_active",   {9'd0, active},    10'd0);
        check("rst_ready",    {9'd0, sym_ready}, 10'd1);
        rst = 1'b1;
`ifndef SERIALIZER_10B_IDLE_COMMA_EN
        syncs = 10'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ser_sync) syncs = syncs + 10'd1;
        end
        check("rst_hold_dropped", syncs, 10'd0);
`else
        repeat (20) @(negedge clk);
`endif
        send(10'($urandom));
        repeat (30) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
